// File: rtl/data_cache_if.sv
// Bus bundle for data_cache: CPU-side word port plus memory-side 128-bit block port.
// master = the cache; slave = the pipeline and data_memory it sits between.
`timescale 1ns/1ps
interface data_cache_if;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_address;
  logic [3:0]   cpu_byteen;
  logic [31:0]  cpu_writedata;
  logic [31:0]  cpu_readdata;
  logic         cpu_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    input  cpu_read, cpu_write, cpu_address, cpu_byteen, cpu_writedata,
    output cpu_readdata, cpu_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    output cpu_read, cpu_write, cpu_address, cpu_byteen, cpu_writedata,
    input  cpu_readdata, cpu_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache (4-word lines) between the
// MEM stage and a block-oriented data memory with a READ/WRITE/BUSYWAIT handshake.
`timescale 1ns/1ps
module data_cache #(
  parameter  int INDEX_BITS = 3,
  localparam int TAG_BITS   = 28 - INDEX_BITS,
  localparam int LINES      = 1 << INDEX_BITS
) (
  input logic          clk,
  input logic          rst,
  data_cache_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t                state;
  logic [127:0]          line_data [LINES];
  logic [TAG_BITS-1:0]   line_tag  [LINES];
  logic [LINES-1:0]      line_valid;
  logic [LINES-1:0]      line_dirty;
  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   miss_tag;
  logic [1:0]            word;
  logic [31:0]           hit_word;
  logic [127:0]          fill_data;
  logic                  hit;
  logic                  req;
  logic                  seen_busy;
  logic                  mem_busy;
  logic                  mem_done;
  logic                  unused_addr_bits;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  assign idx              = bus.cpu_address[4 +: INDEX_BITS];
  assign tag              = bus.cpu_address[31 : 4+INDEX_BITS];
  assign word             = bus.cpu_address[3:2];
  assign unused_addr_bits = ^bus.cpu_address[1:0];
  assign req              = bus.cpu_read | bus.cpu_write;
  assign hit              = line_valid[idx] && (line_tag[idx] == tag);
  assign hit_word         = line_data[idx][{word, 5'b0} +: 32];
  assign mem_busy         = bus.mem_busywait;
  // A transfer is complete only once the memory has been seen busy and then released.
  assign mem_done         = !mem_busy && seen_busy;

  always_comb begin
    bus.cpu_busywait = 1'b1;
    bus.cpu_readdata = '0;
    if (state == IDLE) begin
      bus.cpu_busywait = req && !hit;
      if (bus.cpu_read && hit) bus.cpu_readdata = hit_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_writedata <= '0;
      seen_busy         <= 1'b0;
      line_valid        <= '0;
      line_dirty        <= '0;
      miss_idx          <= '0;
      miss_tag          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (bus.cpu_write) line_dirty[idx] <= 1'b1;
          end else if (req) begin
            // Latch the miss target so a flushed request still completes the fill.
            miss_idx <= idx;
            miss_tag <= tag;
            if (line_valid[idx] && line_dirty[idx]) begin
              state             <= WRITEBACK;
              bus.mem_write     <= 1'b1;
              bus.mem_address   <= {line_tag[idx], idx};
              bus.mem_writedata <= line_data[idx];
            end else begin
              state           <= ALLOCATE;
              bus.mem_read    <= 1'b1;
              bus.mem_address <= {tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (mem_done) begin
            seen_busy       <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_read    <= 1'b1;
            bus.mem_address <= {miss_tag, miss_idx};
            state           <= ALLOCATE;
          end else if (mem_busy) begin
            seen_busy <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (mem_done) begin
            seen_busy    <= 1'b0;
            bus.mem_read <= 1'b0;
            state        <= UPDATE;
          end else if (mem_busy) begin
            seen_busy <= 1'b1;
          end
        end
        UPDATE: begin
          line_valid[miss_idx] <= 1'b1;
          line_dirty[miss_idx] <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mem_done) fill_data <= bus.mem_readdata;
    if (state == UPDATE) begin
      line_data[miss_idx] <= fill_data;
      line_tag[miss_idx]  <= miss_tag;
    end else if (state == IDLE && bus.cpu_write && hit) begin
      line_data[idx][{word, 5'b0} +: 32] <= merge_lanes(hit_word, bus.cpu_writedata, bus.cpu_byteen);
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: block memory with variable latency, directed vectors,
// multi-cycle corner sequences and randomized traffic against a word-level reference.
`timescale 1ns/1ps
module tb_data_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   por = 1'b1;
  always #5 clk = ~clk;

  data_cache_if bus();
  data_cache #(.INDEX_BITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int w);
    return 32'(w) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  function automatic logic [127:0] init_blk(input int b);
    return {init_word(4*b+3), init_word(4*b+2), init_word(4*b+1), init_word(4*b)};
  endfunction

  // ---------------- block memory: 64 blocks, random latency, sometimes late busy
  logic [127:0] mem_blk [64];
  int mphase, mcnt;
  always @(posedge clk) begin
    if (por) begin
      for (int i = 0; i < 64; i++) mem_blk[i] <= init_blk(i);
      mphase <= 0; mcnt <= 0;
      bus.mem_busywait <= 1'b0;
      bus.mem_readdata <= '0;
    end else if (rst) begin
      mphase <= 0;
      bus.mem_busywait <= 1'b0;
    end else begin
      case (mphase)
        0: if (bus.mem_read || bus.mem_write) begin
             mcnt <= $urandom_range(0, 3);
             if ($urandom_range(0, 1) == 1) mphase <= 3;
             else begin mphase <= 1; bus.mem_busywait <= 1'b1; end
           end
        3: begin bus.mem_busywait <= 1'b1; mphase <= 1; end
        1: if (mcnt == 0) begin
             if (bus.mem_write) mem_blk[bus.mem_address[5:0]] <= bus.mem_writedata;
             else bus.mem_readdata <= mem_blk[bus.mem_address[5:0]];
             bus.mem_busywait <= 1'b0;
             mphase <= 2;
           end else mcnt <= mcnt - 1;
        default: mphase <= 0;
      endcase
    end
  end

  // ---------------- memory request monitor
  typedef struct packed { logic kind; logic [27:0] addr; logic [31:0] w0; } mev_t;
  mev_t mq[$];
  logic prev_r = 1'b0, prev_w = 1'b0;
  bit   both_high = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_r <= 1'b0; prev_w <= 1'b0;
    end else begin
      if (bus.mem_read && bus.mem_write) both_high <= 1'b1;
      if (bus.mem_write && !prev_w) mq.push_back({1'b0, bus.mem_address, bus.mem_writedata[31:0]});
      if (bus.mem_read && !prev_r)  mq.push_back({1'b1, bus.mem_address, 32'h0});
      prev_r <= bus.mem_read; prev_w <= bus.mem_write;
    end
  end

  // ---------------- reference state (truth per word, plus residency per line)
  logic [31:0] ref_w [256];
  bit          rv [8];
  bit          rdty [8];
  logic [24:0] rt [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
    bit done;
    stalls = 0; done = 1'b0; rdata = '0;
    bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_address = a;
    bus.cpu_byteen = be; bus.cpu_writedata = wd;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_busywait) stalls++;
      else begin rdata = bus.cpu_readdata; done = 1'b1; end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access timeout: addr %0h still stalled, required completion", a);
    end
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_w[a[9:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  task automatic check_mem(input int id, input bit wb, input logic [27:0] wa, input logic [31:0] w0,
                           input bit fill, input logic [27:0] fa);
    mev_t ev;
    check($sformatf("op%0d mem request count", id), mq.size(), int'(wb) + int'(fill));
    if (wb && mq.size() > 0) begin
      ev = mq.pop_front();
      check($sformatf("op%0d writeback kind", id), ev.kind, 1'b0);
      check($sformatf("op%0d writeback addr", id), ev.addr, wa);
      check($sformatf("op%0d writeback word0", id), ev.w0, w0);
    end
    if (fill && mq.size() > 0) begin
      ev = mq.pop_front();
      check($sformatf("op%0d fill kind", id), ev.kind, 1'b1);
      check($sformatf("op%0d fill addr", id), ev.addr, fa);
    end
    mq.delete();
  endtask

  typedef struct {
    bit rd; bit wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;
    bit miss; bit chk; logic [31:0] rdata;
    bit wb; logic [27:0] wb_addr; logic [31:0] wb_w0; bit fill; logic [27:0] fill_addr;
  } vec_t;

  function automatic vec_t mkv(bit rd, bit wr, logic [31:0] addr, logic [3:0] be, logic [31:0] wd,
                               bit miss, bit chk, logic [31:0] rdata, bit wb, logic [27:0] wba,
                               logic [31:0] wbw0, bit fill, logic [27:0] fa);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wd = wd;
    v.miss = miss; v.chk = chk; v.rdata = rdata;
    v.wb = wb; v.wb_addr = wba; v.wb_w0 = wbw0; v.fill = fill; v.fill_addr = fa;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int stalls;
    logic [31:0] rdata;
    bit got;

    vecs[0] = mkv(1, 0, 32'h10, 4'h0, 32'h0,        1, 1, init_word(4),  0, 28'h0, 32'h0,        1, 28'h1);
    vecs[1] = mkv(0, 1, 32'h20, 4'hF, 32'hABCD1234, 1, 0, 32'h0,         0, 28'h0, 32'h0,        1, 28'h2);
    vecs[2] = mkv(1, 0, 32'h20, 4'h0, 32'h0,        0, 1, 32'hABCD1234,  0, 28'h0, 32'h0,        0, 28'h0);
    vecs[3] = mkv(0, 1, 32'h20, 4'h2, 32'h00005500, 0, 0, 32'h0,         0, 28'h0, 32'h0,        0, 28'h0);
    vecs[4] = mkv(1, 0, 32'h20, 4'h0, 32'h0,        0, 1, 32'hABCD5534,  0, 28'h0, 32'h0,        0, 28'h0);
    vecs[5] = mkv(1, 0, 32'hA0, 4'h0, 32'h0,        1, 1, init_word(40), 1, 28'h2, 32'hABCD5534, 1, 28'hA);
    vecs[6] = mkv(1, 0, 32'h20, 4'h0, 32'h0,        1, 1, 32'hABCD5534,  0, 28'h0, 32'h0,        1, 28'h2);

    for (int i = 0; i < 256; i++) ref_w[i] = init_word(i);
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = 32'h10;
    bus.cpu_byteen = 4'h0; bus.cpu_writedata = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    por = 1'b0;
    check("reset mem_read", bus.mem_read, 1'b0);
    check("reset mem_write", bus.mem_write, 1'b0);
    check("reset mem_address", bus.mem_address, 28'h0);
    check("reset mem_writedata", bus.mem_writedata, 128'h0);
    check("reset cpu_busywait", bus.cpu_busywait, 1'b0);
    check("reset cpu_readdata", bus.cpu_readdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed vectors
    mq.delete();
    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, stalls, rdata);
      check($sformatf("vec%0d miss", i), stalls > 0, vecs[i].miss);
      if (vecs[i].chk) check($sformatf("vec%0d rdata", i), rdata, vecs[i].rdata);
      check_mem(i, vecs[i].wb, vecs[i].wb_addr, vecs[i].wb_w0, vecs[i].fill, vecs[i].fill_addr);
    end

    // request dropped mid-miss: the fill still lands
    bus.cpu_read = 1'b1; bus.cpu_address = 32'h60; got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin @(negedge clk); if (bus.mem_read) got = 1'b1; end
    check("flush fill started", got, 1'b1);
    bus.cpu_read = 1'b0; got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin @(negedge clk); if (!bus.mem_read) got = 1'b1; end
    check("flush fill completed", got, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_mem(100, 0, 28'h0, 32'h0, 1, 28'h6);
    do_access(1, 0, 32'h60, 4'h0, 32'h0, stalls, rdata);
    check("flush line hits", stalls, 0);
    check("flush line data", rdata, init_word(24));

    // reset while allocating
    bus.cpu_read = 1'b1; bus.cpu_address = 32'h50; got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin @(negedge clk); if (bus.mem_read) got = 1'b1; end
    check("alloc before reset", got, 1'b1);
    #2;
    rst = 1'b1;
    bus.cpu_read = 1'b0;
    #1;
    check("reset mid-miss mem_read", bus.mem_read, 1'b0);
    check("reset mid-miss mem_write", bus.mem_write, 1'b0);
    check("reset mid-miss cpu_busywait", bus.cpu_busywait, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    do_access(1, 0, 32'h10, 4'h0, 32'h0, stalls, rdata);
    check("post-reset 0x10 misses", stalls > 0, 1'b1);
    check("post-reset 0x10 data", rdata, init_word(4));
    check_mem(101, 0, 28'h0, 32'h0, 1, 28'h1);

    // read and write together behave as a store
    do_access(1, 1, 32'h30, 4'hF, 32'h13572468, stalls, rdata);
    check("rw store misses", stalls > 0, 1'b1);
    check_mem(102, 0, 28'h0, 32'h0, 1, 28'h3);
    do_access(1, 0, 32'h30, 4'h0, 32'h0, stalls, rdata);
    check("rw store then hit", stalls, 0);
    check("rw store data", rdata, 32'h13572468);
    do_access(1, 0, 32'hB0, 4'h0, 32'h0, stalls, rdata);
    check("rw line evicted dirty data", rdata, init_word(44));
    check_mem(103, 1, 28'h3, 32'h13572468, 1, 28'hB);

    // randomized traffic from an empty cache
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    mq.delete();
    for (int i = 0; i < 8; i++) begin rv[i] = 1'b0; rdty[i] = 1'b0; rt[i] = '0; end
    for (int n = 0; n < 400; n++) begin
      int op, blk, w, ix;
      logic [31:0] a, wd, exp_rd;
      logic [3:0] be;
      bit rd, wr, exp_miss, exp_wb;
      logic [27:0] wba;
      op = $urandom_range(0, 2); blk = $urandom_range(0, 31); w = $urandom_range(0, 3);
      rd = (op != 1); wr = (op != 0);
      a = 32'(blk * 16 + w * 4);
      be = 4'($urandom_range(1, 15)); wd = $urandom;
      ix = blk % 8;
      exp_miss = !(rv[ix] && rt[ix] == 25'(blk / 8));
      exp_wb = exp_miss && rv[ix] && rdty[ix];
      wba = {rt[ix], 3'(ix)};
      exp_rd = ref_w[a[9:2]];
      do_access(rd, wr, a, be, wd, stalls, rdata);
      check($sformatf("rnd%0d miss", n), stalls > 0, exp_miss);
      if (rd && !wr) check($sformatf("rnd%0d rdata", n), rdata, exp_rd);
      check_mem(1000 + n, exp_wb, wba, ref_w[wba * 4], exp_miss, 28'(blk));
      if (exp_miss) begin rv[ix] = 1'b1; rt[ix] = 25'(blk / 8); rdty[ix] = 1'b0; end
      if (wr) rdty[ix] = 1'b1;
    end

    check("mem read/write never overlap", both_high, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
